// File: rtl/id_priv_dispatch_if.sv
// ----------------------------------------------------------------------------
// id_priv_dispatch_if
//
// Purpose: bundles the instruction-buffer side and the dispatch-queue side of
// the privileged/counter/TLB decode stage into one interface.
//
// Handshake: both sides use valid/ready. A bundle moves on a rising clock
// edge when valid is non-zero and ready is high in the same cycle. A producer
// holds valid and its payload stable until that edge. Ready does not depend
// combinationally on this side's own valid.
//
// Signals (ISSUE_WIDTH lanes, lane i occupies bits [i*W +: W]):
//   in_valid/in_ready/in_pc/in_inst      instruction buffer -> stage
//   out_valid/out_ready                  stage -> dispatch queue handshake
//   out_pc/out_inst                      lane passthrough
//   out_aluop/out_alusel                 ALU operation and operand select
//   out_reg_write_en/out_reg_write_addr  GPR writeback
//   out_csr_read_en/out_csr_write_en/out_csr_addr
//   out_is_privilege/out_is_cnt/out_inst_valid/out_exception_cause
//
// Modports: slave = the decode stage, master = the surrounding pipeline.
// ----------------------------------------------------------------------------
interface id_priv_dispatch_if #(
    parameter int ISSUE_WIDTH = 2
);
    logic [ISSUE_WIDTH-1:0]    in_valid;
    logic                      in_ready;
    logic [32*ISSUE_WIDTH-1:0] in_pc;
    logic [32*ISSUE_WIDTH-1:0] in_inst;

    logic [ISSUE_WIDTH-1:0]    out_valid;
    logic                      out_ready;
    logic [32*ISSUE_WIDTH-1:0] out_pc;
    logic [32*ISSUE_WIDTH-1:0] out_inst;
    logic [8*ISSUE_WIDTH-1:0]  out_aluop;
    logic [3*ISSUE_WIDTH-1:0]  out_alusel;
    logic [ISSUE_WIDTH-1:0]    out_reg_write_en;
    logic [5*ISSUE_WIDTH-1:0]  out_reg_write_addr;
    logic [ISSUE_WIDTH-1:0]    out_csr_read_en;
    logic [ISSUE_WIDTH-1:0]    out_csr_write_en;
    logic [14*ISSUE_WIDTH-1:0] out_csr_addr;
    logic [ISSUE_WIDTH-1:0]    out_is_privilege;
    logic [ISSUE_WIDTH-1:0]    out_is_cnt;
    logic [ISSUE_WIDTH-1:0]    out_inst_valid;
    logic [7*ISSUE_WIDTH-1:0]  out_exception_cause;

    modport slave (
        input  in_valid, in_pc, in_inst, out_ready,
        output in_ready, out_valid, out_pc, out_inst, out_aluop, out_alusel,
               out_reg_write_en, out_reg_write_addr, out_csr_read_en,
               out_csr_write_en, out_csr_addr, out_is_privilege, out_is_cnt,
               out_inst_valid, out_exception_cause
    );

    modport master (
        output in_valid, in_pc, in_inst, out_ready,
        input  in_ready, out_valid, out_pc, out_inst, out_aluop, out_alusel,
               out_reg_write_en, out_reg_write_addr, out_csr_read_en,
               out_csr_write_en, out_csr_addr, out_is_privilege, out_is_cnt,
               out_inst_valid, out_exception_cause
    );
endinterface

// File: rtl/id_priv_dispatch.sv
// ----------------------------------------------------------------------------
// id_priv_dispatch
//
// Purpose: registered ISSUE_WIDTH-lane decode/dispatch stage for ERTN,
// RDCNTID/RDCNTVLW, RDCNTVHW and TLBSRCH/TLBRD/TLBWR/TLBFILL. Privileged
// instructions issue alone in lane 0; bundles are split as needed and the
// not-yet-issued lanes wait in a residual buffer (state SPLIT). Unknown
// opcodes decode as not-valid so a general decoder can override them.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   flush        drops the output register and residual buffer, blocks input
//   bus          id_priv_dispatch_if.slave (input bundle, output bundle)
//   dbg_state_o  1 while in SPLIT, 0 while in NORMAL
//
// Build option: define ID_TLB_EN to decode the TLB opcodes; without it they
// decode like any unknown opcode and never cause a split.
// ----------------------------------------------------------------------------
module id_priv_dispatch #(
    parameter int ISSUE_WIDTH = 2,
    parameter int LANE_W      = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    id_priv_dispatch_if.slave      bus,
    output logic                   dbg_state_o
);
    localparam int IW = ISSUE_WIDTH;

    localparam logic [21:0] OP_ERTN     = 22'h01920E;
    localparam logic [21:0] OP_RDCNT    = 22'h000018;
    localparam logic [21:0] OP_RDCNTVHW = 22'h000019;
    localparam logic [7:0]  ALU_NOP      = 8'h00;
    localparam logic [7:0]  ALU_RDCNTVLW = 8'h60;
    localparam logic [7:0]  ALU_RDCNTVHW = 8'h61;
    localparam logic [7:0]  ALU_RDCNTID  = 8'h62;
    localparam logic [7:0]  ALU_ERTN     = 8'h70;
`ifdef ID_TLB_EN
    localparam logic [21:0] OP_TLBSRCH  = 22'h01920A;
    localparam logic [21:0] OP_TLBRD    = 22'h01920B;
    localparam logic [21:0] OP_TLBWR    = 22'h01920C;
    localparam logic [21:0] OP_TLBFILL  = 22'h01920D;
    localparam logic [7:0]  ALU_TLBSRCH  = 8'h71;
    localparam logic [7:0]  ALU_TLBRD    = 8'h72;
    localparam logic [7:0]  ALU_TLBWR    = 8'h73;
    localparam logic [7:0]  ALU_TLBFILL  = 8'h74;
`endif
    localparam logic [2:0]  SEL_NOP = 3'd0;
    localparam logic [2:0]  SEL_CSR = 3'd6;
    localparam logic [13:0] CSR_TID = 14'h040;
    localparam logic [6:0]  EXCEPTION_INE = 7'h0D;

    typedef enum logic {ST_NORMAL = 1'b0, ST_SPLIT = 1'b1} state_t;

    typedef struct packed {
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic        wen;
        logic [4:0]  waddr;
        logic        csr_rd;
        logic        csr_wr;
        logic [13:0] csr_addr;
        logic        priv;
        logic        cnt;
        logic        valid;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] inst);
        dec_t        d;
        logic [21:0] op;
        op         = inst[31:10];
        d          = '0;
        d.aluop    = ALU_NOP;
        d.alusel   = SEL_NOP;
        d.csr_addr = CSR_TID;
        case (op)
            OP_ERTN: begin
                d.valid = 1'b1;
                d.priv  = 1'b1;
                d.aluop = ALU_ERTN;
            end
            OP_RDCNT: begin
                d.valid  = 1'b1;
                d.cnt    = 1'b1;
                d.wen    = 1'b1;
                d.alusel = SEL_CSR;
                // rj selects between the counter id read and the low word read
                if (inst[9:5] == 5'd0) begin
                    d.aluop = ALU_RDCNTVLW;
                    d.waddr = inst[4:0];
                end else begin
                    d.aluop  = ALU_RDCNTID;
                    d.waddr  = inst[9:5];
                    d.csr_rd = 1'b1;
                end
            end
            OP_RDCNTVHW: begin
                d.valid  = 1'b1;
                d.cnt    = 1'b1;
                d.wen    = 1'b1;
                d.alusel = SEL_CSR;
                d.aluop  = ALU_RDCNTVHW;
                d.waddr  = inst[4:0];
            end
`ifdef ID_TLB_EN
            OP_TLBSRCH, OP_TLBRD, OP_TLBWR, OP_TLBFILL: begin
                d.valid    = 1'b1;
                d.priv     = 1'b1;
                d.alusel   = SEL_CSR;
                d.csr_wr   = 1'b1;
                d.csr_addr = 14'h3FFF;
                d.wen      = (op == OP_TLBRD);
                case (op)
                    OP_TLBSRCH: d.aluop = ALU_TLBSRCH;
                    OP_TLBRD:   d.aluop = ALU_TLBRD;
                    OP_TLBWR:   d.aluop = ALU_TLBWR;
                    default:    d.aluop = ALU_TLBFILL;
                endcase
            end
`endif
            default: ;
        endcase
        return d;
    endfunction

    state_t               state_q, state_d;
    logic [IW-1:0]        out_valid_q, out_valid_d;
    logic [32*IW-1:0]     out_pc_q, out_pc_d, out_inst_q, out_inst_d;
    dec_t                 out_dec_q [IW];
    dec_t                 out_dec_d [IW];
    logic [IW-1:0]        res_valid_q, res_valid_d;
    logic [32*IW-1:0]     res_pc_q, res_pc_d, res_inst_q, res_inst_d;

    logic [IW-1:0]        src_valid;
    logic [32*IW-1:0]     src_pc, src_inst;
    dec_t                 src_dec [IW];
    logic                 found_priv;
    logic [LANE_W:0]      split_at;
    logic [IW-1:0]        issue_mask;
    logic [IW-1:0]        res_valid_n;
    logic [32*IW-1:0]     res_pc_n, res_inst_n;
    logic                 out_free, load;

    assign out_free    = (out_valid_q == '0) || bus.out_ready;
    assign bus.in_ready = (state_q == ST_NORMAL) && out_free && !flush;
    // In SPLIT the residual always holds at least one lane, so it issues as
    // soon as the output register frees up.
    assign load        = !flush && out_free &&
                         ((state_q == ST_SPLIT) || (bus.in_valid != '0));
    assign dbg_state_o = (state_q == ST_SPLIT);

    // Source bundle, split point and re-packed residual.
    always_comb begin
        src_valid = bus.in_valid;
        src_pc    = bus.in_pc;
        src_inst  = bus.in_inst;
        if (state_q == ST_SPLIT) begin
            src_valid = res_valid_q;
            src_pc    = res_pc_q;
            src_inst  = res_inst_q;
        end
        for (int i = 0; i < IW; i++) begin
            src_dec[i] = decode(src_inst[i*32 +: 32]);
        end
        // split_at = first lane that does not issue this time (IW = all issue).
        // A privileged lane 0 issues alone, otherwise lanes before it issue.
        found_priv = 1'b0;
        split_at   = (LANE_W+1)'(IW);
        for (int i = 0; i < IW; i++) begin
            if (!found_priv && src_valid[i] && src_dec[i].priv) begin
                found_priv = 1'b1;
                split_at   = (i == 0) ? (LANE_W+1)'(1) : (LANE_W+1)'(i);
            end
        end
        for (int i = 0; i < IW; i++) begin
            issue_mask[i] = src_valid[i] && (i < int'(split_at));
        end
        res_valid_n = '0;
        res_pc_n    = '0;
        res_inst_n  = '0;
        for (int j = 0; j < IW; j++) begin
            for (int s = 0; s < IW; s++) begin
                if (s == j + int'(split_at)) begin
                    res_valid_n[j]        = src_valid[s];
                    res_pc_n[j*32 +: 32]   = src_pc[s*32 +: 32];
                    res_inst_n[j*32 +: 32] = src_inst[s*32 +: 32];
                end
            end
        end
    end

    // Next state for the FSM, output register and residual buffer.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_pc_d    = out_pc_q;
        out_inst_d  = out_inst_q;
        res_valid_d = res_valid_q;
        res_pc_d    = res_pc_q;
        res_inst_d  = res_inst_q;
        for (int i = 0; i < IW; i++) begin
            out_dec_d[i] = out_dec_q[i];
        end
        if (flush) begin
            state_d     = ST_NORMAL;
            out_valid_d = '0;
            out_pc_d    = '0;
            out_inst_d  = '0;
            res_valid_d = '0;
            res_pc_d    = '0;
            res_inst_d  = '0;
            for (int i = 0; i < IW; i++) begin
                out_dec_d[i] = '0;
            end
        end else if (load) begin
            out_valid_d = issue_mask;
            for (int i = 0; i < IW; i++) begin
                out_pc_d[i*32 +: 32]   = issue_mask[i] ? src_pc[i*32 +: 32] : 32'd0;
                out_inst_d[i*32 +: 32] = issue_mask[i] ? src_inst[i*32 +: 32] : 32'd0;
                out_dec_d[i]           = issue_mask[i] ? src_dec[i] : '0;
            end
            res_valid_d = res_valid_n;
            res_pc_d    = res_pc_n;
            res_inst_d  = res_inst_n;
            state_d     = (res_valid_n != '0) ? ST_SPLIT : ST_NORMAL;
        end else if (out_free) begin
            // Bundle transferred (or register already empty) with nothing new.
            out_valid_d = '0;
            out_pc_d    = '0;
            out_inst_d  = '0;
            for (int i = 0; i < IW; i++) begin
                out_dec_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_NORMAL;
            out_valid_q <= '0;
            out_pc_q    <= '0;
            out_inst_q  <= '0;
            res_valid_q <= '0;
            res_pc_q    <= '0;
            res_inst_q  <= '0;
            for (int i = 0; i < IW; i++) begin
                out_dec_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_inst_q  <= out_inst_d;
            res_valid_q <= res_valid_d;
            res_pc_q    <= res_pc_d;
            res_inst_q  <= res_inst_d;
            for (int i = 0; i < IW; i++) begin
                out_dec_q[i] <= out_dec_d[i];
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_pc    = out_pc_q;
    assign bus.out_inst  = out_inst_q;

    for (genvar g = 0; g < IW; g++) begin : g_lane
        assign bus.out_aluop[g*8 +: 8]           = out_dec_q[g].aluop;
        assign bus.out_alusel[g*3 +: 3]          = out_dec_q[g].alusel;
        assign bus.out_reg_write_en[g]           = out_dec_q[g].wen;
        assign bus.out_reg_write_addr[g*5 +: 5]  = out_dec_q[g].waddr;
        assign bus.out_csr_read_en[g]            = out_dec_q[g].csr_rd;
        assign bus.out_csr_write_en[g]           = out_dec_q[g].csr_wr;
        assign bus.out_csr_addr[g*14 +: 14]      = out_dec_q[g].csr_addr;
        assign bus.out_is_privilege[g]           = out_dec_q[g].priv;
        assign bus.out_is_cnt[g]                 = out_dec_q[g].cnt;
        assign bus.out_inst_valid[g]             = out_dec_q[g].valid;
        // Every issued lane carries INE for the general decoder to override.
        assign bus.out_exception_cause[g*7 +: 7] = out_valid_q[g] ? EXCEPTION_INE : 7'd0;
    end
endmodule
